snake_core_grid: RTL

- Parametrised successor to the fixed 16x16 snake game core: configurable grid dimensions, maximum snake length, and game speed.
- Separate X/Y coordinates give true wall detection.
- Food generation avoids the snake body; 180-degree reversals are rejected.
- Sits between the debounced button inputs and the VGA/display renderer, which consumes Food, Length, Locations_Flat and the one-hot state flags.

---
 rtl/snake_core_grid.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/snake_core_grid.sv
// Snake game core on a 2^XW x 2^YW grid: direction capture, food placement off the body, moves, collisions.
// Optional build macro SNAKE_WRAP_EN: walls wrap around instead of losing.
module snake_core_grid #(
  parameter int          XW          = 4,
  parameter int          YW          = 4,
  parameter int          MAX_LEN     = 16,
  parameter int          TICK_CYCLES = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  localparam int         PW          = XW + YW,
  localparam int         LW          = $clog2(MAX_LEN + 1)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Left,
  input  logic                    Right,
  input  logic                    Up,
  input  logic                    Down,
  input  logic                    Ack,
  output logic                    Qi,
  output logic                    Qf,
  output logic                    Qh,
  output logic                    Qm,
  output logic                    Qc,
  output logic                    Qe,
  output logic                    Qw,
  output logic                    Ql,
  output logic                    Qu,
  output logic [PW-1:0]           Food,
  output logic [LW-1:0]           Length,
  output logic [MAX_LEN*PW-1:0]   Locations_Flat,
  output logic [MAX_LEN-1:0]      Live_Mask
);

  localparam int HW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [XW-1:0] X0    = XW'(1 << (XW - 1));
  localparam logic [YW-1:0] Y0    = YW'(1 << (YW - 1));
  localparam logic [PW-1:0] HEAD0 = {Y0, X0};
  localparam logic [PW-1:0] TAIL0 = {Y0, X0 - XW'(1)};

  typedef enum logic [3:0] {
    S_INIT, S_FOOD, S_HOLD, S_MOVE, S_CHECK, S_EAT, S_WIN, S_LOSE, S_UNKN
  } state_t;

  // LEFT^RIGHT and UP^DOWN both equal 2'b01, which makes the reversal test a single xor.
  typedef enum logic [1:0] {D_LEFT, D_RIGHT, D_UP, D_DOWN} dir_t;

  state_t          state, state_nxt;
  dir_t            cur_dir, next_dir, req_dir;
  logic [PW-1:0]   loc [MAX_LEN];
  logic [15:0]     lfsr, lfsr_nxt;
  logic [HW-1:0]   hold_cnt;
  logic [XW-1:0]   hx, new_x;
  logic [YW-1:0]   hy, new_y;
  logic [PW-1:0]   cand, new_head;
  logic [LW-1:0]   len_inc;
  logic            req_valid, wall, wall_lose, self_hit, food_hit, eat_hit;

  assign hx       = loc[0][XW-1:0];
  assign hy       = loc[0][PW-1:XW];
  assign new_head = {new_y, new_x};
  assign cand     = lfsr[PW-1:0];
  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign len_inc  = Length + 1'b1;
  assign eat_hit  = (loc[0] == Food);

  assign req_valid = Left | Right | Up | Down;
  assign req_dir   = Left ? D_LEFT : Right ? D_RIGHT : Up ? D_UP : D_DOWN;

  always_comb begin
    new_x = hx;
    new_y = hy;
    wall  = 1'b0;
    case (next_dir)
      D_LEFT:  begin new_x = hx - 1'b1; wall = (hx == '0); end
      D_RIGHT: begin new_x = hx + 1'b1; wall = &hx;        end
      D_UP:    begin new_y = hy - 1'b1; wall = (hy == '0); end
      default: begin new_y = hy + 1'b1; wall = &hy;        end
    endcase
`ifdef SNAKE_WRAP_EN
    wall_lose = 1'b0;
`else
    wall_lose = wall;
`endif
  end

  always_comb begin
    self_hit = 1'b0;
    food_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++)
      if (LW'(i) < Length && loc[i] == loc[0]) self_hit = 1'b1;
    for (int i = 0; i < MAX_LEN; i++)
      if (LW'(i) < Length && loc[i] == cand) food_hit = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (Ack) state_nxt = S_FOOD;
      S_FOOD:  if (!food_hit) state_nxt = S_HOLD;
      S_HOLD:  if (hold_cnt == '0) state_nxt = S_MOVE;
      S_MOVE:  state_nxt = wall_lose ? S_LOSE : S_CHECK;
      S_CHECK: state_nxt = self_hit ? S_LOSE : (eat_hit ? S_EAT : S_HOLD);
      S_EAT:   state_nxt = (len_inc == LW'(MAX_LEN)) ? S_WIN : S_FOOD;
      S_WIN,
      S_LOSE:  if (Ack) state_nxt = S_INIT;
      default: state_nxt = S_UNKN;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Length   <= LW'(2);
      Food     <= '0;
      cur_dir  <= D_RIGHT;
      next_dir <= D_RIGHT;
      lfsr     <= LFSR_SEED;
      hold_cnt <= '0;
    end else if (state == S_INIT) begin
      Length   <= LW'(2);
      Food     <= '0;
      cur_dir  <= D_RIGHT;
      next_dir <= D_RIGHT;
      lfsr     <= LFSR_SEED;
      hold_cnt <= '0;
    end else begin
      if (req_valid && ((req_dir ^ cur_dir) != 2'b01)) next_dir <= req_dir;
      if (state == S_FOOD) begin
        lfsr <= lfsr_nxt;
        if (!food_hit) Food <= cand;
      end
      if (state == S_MOVE && !wall_lose) cur_dir <= next_dir;
      if (state == S_EAT) Length <= len_inc;
      if (state_nxt == S_HOLD && state != S_HOLD) hold_cnt <= HW'(TICK_CYCLES - 1);
      else if (state == S_HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // Shifting every index below Length leaves the old tail one slot past the live region, so EAT only bumps Length.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < MAX_LEN; i++) loc[i] <= '0;
      loc[0] <= HEAD0;
      loc[1] <= TAIL0;
    end else if (state == S_INIT) begin
      for (int i = 0; i < MAX_LEN; i++) loc[i] <= '0;
      loc[0] <= HEAD0;
      loc[1] <= TAIL0;
    end else if (state == S_MOVE && !wall_lose) begin
      for (int i = 0; i < MAX_LEN - 1; i++)
        if (LW'(i) < Length) loc[i+1] <= loc[i];
      loc[0] <= new_head;
    end
  end

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_out
    assign Locations_Flat[(MAX_LEN-g)*PW-1 -: PW] = loc[g];
    assign Live_Mask[g] = (LW'(g) < Length);
  end

  assign Qi = (state == S_INIT);
  assign Qf = (state == S_FOOD);
  assign Qh = (state == S_HOLD);
  assign Qm = (state == S_MOVE);
  assign Qc = (state == S_CHECK);
  assign Qe = (state == S_EAT);
  assign Qw = (state == S_WIN);
  assign Ql = (state == S_LOSE);
  assign Qu = (state == S_UNKN);

endmodule
